// File: rtl/systolic_dct_1d_param.sv
// systolic_dct_1d_param: N-point 1-D DCT as a linear chain of N multiply-accumulate PEs.
// Samples enter PE0 and ripple one PE per cycle. PE k builds Y[k] from a runtime-writable
// coefficient table. A one-deep output buffer lets the next block stream in while the
// consumer holds off out_ready.
module systolic_dct_1d_param #(
    parameter int N         = 8,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(N),
    parameter int OUT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      coef_we,
    input  logic [$clog2(N*N)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]  coef_wdata,
    output logic [N*OUT_W-1:0]        out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      done,
    output logic                      busy
);

    localparam int          IW = $clog2(N);
    localparam int          DW = $clog2(N + 1);
    localparam int          AW = $clog2(N * N);
    localparam int unsigned NN = N * N;
    localparam int          WW = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;

    typedef enum logic [1:0] {S_ACCEPT, S_DRAIN, S_WAIT} state_t;

    state_t                     state, next_state;
    logic [IW-1:0]              cnt;
    logic [DW-1:0]              dcnt;
    logic signed [DATA_W-1:0]   st_data  [N];
    logic                       st_valid [N];
    logic [IW-1:0]              st_idx   [N];
    logic signed [ACC_W-1:0]    acc      [N];
    logic signed [ACC_W-1:0]    prod     [N];
    logic signed [COEF_W-1:0]   coef     [N*N];
    logic [N*OUT_W-1:0]         scaled;
    logic                       accept, last, drain_done, buf_free, copy;

    // Round half toward +inf, drop the fraction bits, then clamp into the signed OUT_W range.
    function automatic logic [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
        logic signed [WW-1:0] w, rnd, maxv, minv;
        w = {{(WW-ACC_W){a[ACC_W-1]}}, a};
        rnd = '0;
        rnd[FRAC_BITS-1] = 1'b1;
        w = (w + rnd) >>> FRAC_BITS;
        maxv = '0;
        maxv[OUT_W-2:0] = '1;
        minv = ~maxv;
        if (w > maxv)      return maxv[OUT_W-1:0];
        else if (w < minv) return minv[OUT_W-1:0];
        else               return w[OUT_W-1:0];
    endfunction

    assign accept     = in_valid && in_ready;
    assign last       = accept && (cnt == IW'(N - 1));
    assign drain_done = (state == S_DRAIN) && (dcnt == DW'(N));
    assign buf_free   = !out_valid || out_ready;
    assign copy       = (drain_done || state == S_WAIT) && buf_free;

    // State register for the accept/drain/wait sequencer.
    always_ff @(posedge clk) begin
        if (rst) state <= S_ACCEPT;
        else     state <= next_state;
    end

    // Next state: the last sample starts the drain, which ends in a copy or a wait for the buffer.
    always_comb begin
        next_state = state;
        case (state)
            S_ACCEPT: if (last)       next_state = S_DRAIN;
            S_DRAIN:  if (drain_done) next_state = copy ? S_ACCEPT : S_WAIT;
            S_WAIT:   if (copy)       next_state = S_ACCEPT;
            default:                  next_state = S_ACCEPT;
        endcase
    end

    // Handshake outputs: busy spans from the first accepted sample until the block is copied out.
    always_comb begin
        in_ready = (state == S_ACCEPT);
        busy     = (state != S_ACCEPT) || (cnt != '0);
    end

    // Sample index within the block, and the drain timer that waits for PE N-1 to finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dcnt <= '0;
        end else begin
            if (accept) cnt <= last ? '0 : cnt + IW'(1);
            if (state == S_DRAIN) dcnt <= drain_done ? '0 : dcnt + DW'(1);
            else                  dcnt <= '0;
        end
    end

    // Systolic sample pipeline: each stage carries {sample, valid, index} one PE further south.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                st_valid[k] <= 1'b0;
                st_data[k]  <= '0;
                st_idx[k]   <= '0;
            end
        end else begin
            st_valid[0] <= accept;
            st_data[0]  <= in_data;
            st_idx[0]   <= cnt;
            for (int k = 1; k < N; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_data[k]  <= st_data[k-1];
                st_idx[k]   <= st_idx[k-1];
            end
        end
    end

    // Full-precision products; truncating the sign-extended operands to ACC_W is exact here.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod[k] = {{(ACC_W-DATA_W){st_data[k][DATA_W-1]}}, st_data[k]}
                    * {{(ACC_W-COEF_W){coef[AW'(k*N) + AW'(st_idx[k])][COEF_W-1]}},
                       coef[AW'(k*N) + AW'(st_idx[k])]};
        end
    end

    // PE accumulators: n==0 restarts the sum, bubbles leave the sum untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) acc[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (st_valid[k]) acc[k] <= (st_idx[k] == '0) ? prod[k] : acc[k] + prod[k];
            end
        end
    end

    // Coefficient table; writes are locked out while a block is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N*N; i++) coef[i] <= '0;
        end else if (coef_we && !busy && (32'(coef_addr) < NN)) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Rounded and saturated view of every accumulator, ready to be copied into the buffer.
    always_comb begin
        scaled = '0;
        for (int k = 0; k < N; k++) scaled[k*OUT_W +: OUT_W] = scale_sat(acc[k]);
    end

    // One-deep output buffer: load on copy, release on out_ready, a copy wins over a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
        end else begin
            done <= copy;
            if (copy) begin
                out_data  <= scaled;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_dct_1d_param.sv
// tb_systolic_dct_1d_param: directed test of a 4-point engine with 16-bit results.
module tb_systolic_dct_1d_param;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int OUT_W  = 16;
    localparam int AW     = $clog2(N*N);

    logic                     clk;
    logic                     rst;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic [N*OUT_W-1:0]       out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     done;
    logic                     busy;

    int check_count = 0;
    int pass_count  = 0;

    systolic_dct_1d_param #(
        .N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(14), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .busy(busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic longint y_out(input int k);
        logic signed [OUT_W-1:0] v;
        v = out_data[k*OUT_W +: OUT_W];
        return longint'(v);
    endfunction

    task automatic checkY(input string tag, input longint e0, input longint e1,
                          input longint e2, input longint e3);
        checkOutput({tag, "_y0"}, y_out(0), e0);
        checkOutput({tag, "_y1"}, y_out(1), e1);
        checkOutput({tag, "_y2"}, y_out(2), e2);
        checkOutput({tag, "_y3"}, y_out(3), e3);
    endtask

    task automatic applyStimulus(input logic signed [DATA_W-1:0] s);
        in_data  = s;
        in_valid = 1'b1;
        stepClock();
        in_valid = 1'b0;
    endtask

    task automatic sendBlock(input logic signed [DATA_W-1:0] s0, input logic signed [DATA_W-1:0] s1,
                             input logic signed [DATA_W-1:0] s2, input logic signed [DATA_W-1:0] s3);
        applyStimulus(s0);
        applyStimulus(s1);
        applyStimulus(s2);
        applyStimulus(s3);
    endtask

    task automatic writeCoef(input int addr, input logic signed [COEF_W-1:0] val);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = val;
        stepClock();
        coef_we    = 1'b0;
    endtask

    task automatic loadAll(input logic signed [COEF_W-1:0] val);
        for (int a = 0; a < N*N; a++) writeCoef(a, val);
    endtask

    task automatic waitOutValid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            stepClock();
            lat++;
        end
        checkOutput(tag, lat, exp_lat);
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        stepClock();
        stepClock();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_data", longint'(out_data), 0);

        $display("[TB] all-ones coefficients, back-to-back samples");
        loadAll(16'sh4000);
        applyStimulus(16'sd1);
        checkOutput("t1_busy_first", busy, 1);
        applyStimulus(16'sd2);
        applyStimulus(16'sd3);
        applyStimulus(16'sd4);
        checkOutput("t1_in_ready_drain", in_ready, 0);
        waitOutValid("t1_latency", N + 1);
        checkY("t1", 10, 10, 10, 10);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_busy_after", busy, 0);
        stepClock();
        checkOutput("t1_out_valid_fall", out_valid, 0);
        checkOutput("t1_done_pulse", done, 0);

        $display("[TB] identity coefficients with a bubble");
        for (int a = 0; a < N*N; a++) writeCoef(a, (a / N == a % N) ? 16'sh4000 : 16'sh0000);
        applyStimulus(16'sd100);
        applyStimulus(-16'sd200);
        stepClock();
        stepClock();
        applyStimulus(16'sd300);
        applyStimulus(-16'sd400);
        waitOutValid("t2_latency", N + 1);
        checkY("t2", 100, -200, 300, -400);

        $display("[TB] rounding");
        loadAll(16'sh0000);
        writeCoef(0, 16'sh2000);
        sendBlock(16'sd3, 16'sd0, 16'sd0, 16'sd0);
        waitOutValid("t3_latency_pos", N + 1);
        checkY("t3_pos", 2, 0, 0, 0);
        sendBlock(-16'sd3, 16'sd0, 16'sd0, 16'sd0);
        waitOutValid("t3_latency_neg", N + 1);
        checkOutput("t3_neg_y0", y_out(0), -1);

        $display("[TB] saturation");
        loadAll(16'sh7FFF);
        sendBlock(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
        waitOutValid("t4_latency_pos", N + 1);
        checkY("t4_pos", 32767, 32767, 32767, 32767);
        sendBlock(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
        waitOutValid("t4_latency_neg", N + 1);
        checkY("t4_neg", -32768, -32768, -32768, -32768);

        $display("[TB] backpressure");
        loadAll(16'sh4000);
        out_ready = 1'b0;
        sendBlock(16'sd1, 16'sd1, 16'sd1, 16'sd1);
        waitOutValid("t5_latency", N + 1);
        checkOutput("t5_blk1_y0", y_out(0), 4);
        sendBlock(16'sd2, 16'sd2, 16'sd2, 16'sd2);
        repeat (8) stepClock();
        checkOutput("t5_wait_in_ready", in_ready, 0);
        checkOutput("t5_wait_busy", busy, 1);
        checkOutput("t5_wait_out_valid", out_valid, 1);
        checkY("t5_held", 4, 4, 4, 4);
        out_ready = 1'b1;
        stepClock();
        out_ready = 1'b0;
        checkOutput("t5_swap_out_valid", out_valid, 1);
        checkY("t5_blk2", 8, 8, 8, 8);
        checkOutput("t5_swap_done", done, 1);
        checkOutput("t5_swap_in_ready", in_ready, 1);
        checkOutput("t5_swap_busy", busy, 0);
        out_ready = 1'b1;
        stepClock();
        checkOutput("t5_release", out_valid, 0);

        $display("[TB] reset in mid-block");
        applyStimulus(16'sd5);
        applyStimulus(16'sd5);
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        checkOutput("t6_out_valid", out_valid, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_in_ready", in_ready, 1);
        checkOutput("t6_out_data", longint'(out_data), 0);
        loadAll(16'sh4000);
        sendBlock(16'sd1, 16'sd1, 16'sd1, 16'sd1);
        waitOutValid("t6_latency", N + 1);
        checkY("t6", 4, 4, 4, 4);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/systolic_dct_1d_param.md
Name: systolic_dct_1d_param

Overview:
Parametrised N-point 1-D DCT engine built as a linear systolic chain of N multiply-accumulate PEs. Samples enter PE0 and ripple south one PE per cycle. PE k multiplies each sample by its row coefficient C[k][n] and accumulates, so it produces Y[k]. Adds what the fixed 4-point array lacks: a runtime-writable coefficient table, valid/ready handshakes on both sides, bubble tolerance, rounding/saturation, and a one-deep output buffer so block i+1 can stream in while block i waits for out_ready. Sits between the sample framer and the 2-D transpose stage.

Parameters:
N, 8, number of points, equal to the number of PEs (2..16)
DATA_W, 16, signed sample width
COEF_W, 16, signed coefficient width, Q(COEF_W-FRAC_BITS).FRAC_BITS
FRAC_BITS, 14, fractional bits of the coefficient (>=1)
ACC_W, DATA_W+COEF_W+clog2(N), accumulator width, no internal overflow
OUT_W, 32, signed result width after scaling

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_data  in  DATA_W  signed sample x[n], in order n=0..N-1
in_valid  in  1  sample present
in_ready  out  1  engine can accept a sample this cycle
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(N*N)  address = k*N + n
coef_wdata  in  COEF_W  signed coefficient value
out_data  out  N*OUT_W  Y[k] at bits [k*OUT_W +: OUT_W]
out_valid  out  1  out_data holds a complete block
out_ready  in  1  consumer accepts out_data
done  out  1  one-cycle pulse when a block enters the output buffer
busy  out  1  a block is being accepted or draining

Behaviour:
- Reset: out_valid=0, done=0, busy=0, in_ready=1, out_data=0. Reset clears all accumulators, pipeline valid bits, the sample counter and all coefficients to 0. A reset in mid-block aborts the block and discards partial sums. There is no partial output.
- Input transfer: in_valid && in_ready. The sample counter counts 0..N-1. The transfer at count N-1 closes the block.
- Pipeline: each stage carries {sample, valid, index n}. A sample accepted at edge t is accumulated by PE k at edge t+k+1. Bubbles (in_valid low) travel as invalid stages, and PEs hold their accumulator on invalid stages.
- Each PE adds C[k][n]*x[n] (full-precision signed product) into an ACC_W accumulator. The first valid sample of a block (n==0) loads the accumulator instead of adding.
- State machine:
  - ACCEPT: in_ready=1. The last sample moves to DRAIN.
  - DRAIN: in_ready=0 for N cycles, until PE N-1 has accumulated x[N-1].
  - At the end of DRAIN, if the buffer is free (out_valid==0, or out_ready this cycle), copy all Y[k] into the buffer, pulse done, set out_valid and go to ACCEPT. Otherwise go to WAIT.
  - WAIT: in_ready=0. Hold the accumulators. Copy when the buffer frees.
- Latency: with an empty buffer, out_valid rises exactly N+1 edges after the transfer of x[N-1].
- Scaling: Y = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half toward +inf. Then saturate to the signed OUT_W range.
- Output handshake: out_data is stable while out_valid=1. out_valid falls the cycle after out_valid && out_ready, unless a new copy occurs in the same cycle, in which case it stays 1 with new data.
- busy=1 from the first accepted sample until the copy into the buffer.
- Coefficient writes take effect on the next edge. Writes while busy=1 are ignored, so coefficients are stable within a block. Reads are internal only.
- Simultaneous coef_we and in_valid while idle: the write completes, and the sample uses the value present at its accumulate edge.

Test Plan:
- N=4, all C=0x4000 (1.0), samples 1,2,3,4 back-to-back, out_ready=1 -> out_valid 5 edges after the last sample, Y0..Y3=10 each, single done pulse.
- N=4, C[k][n]=0x4000 when k==n else 0, samples 100,-200,300,-400 with a 2-cycle bubble after the 2nd sample -> Y=100,-200,300,-400, latency still measured from the last sample.
- Rounding: C[0][0]=0x2000 (0.5), other coefficients 0. Sample 3 gives Y0=2; sample -3 gives Y0=-1.
- Saturation (OUT_W=16): all C=0x7FFF, samples 32767 x4 -> every Y=32767. Samples -32768 x4 -> every Y=-32768.
- Backpressure: out_ready=0, two blocks sent -> block 2 stalls in WAIT with in_ready=0 and block 1 is held unchanged. Raising out_ready for one cycle releases block 1, then block 2 appears the next cycle.
- Reset after 2 of 4 samples -> all outputs return to reset values. A fresh block of 1,1,1,1 with C reloaded to 0x4000 gives Y=4 with no residue.
